sort_collector: RTL



---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_collector_ram.sv | 30 +++
 rtl/sort_collector.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the systolic sorter datapath: FSM encoding and
// a constant-evaluable ceil(log2) used to size pointers and counters.
package sort_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   // Smallest r with 2**r >= n; usable in parameter expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/sort_collector_ram.sv
// Simple dual-port buffer: one write port, one registered read port with
// read enable so the last read word is held while the consumer stalls.
// The array has no reset so it maps onto block RAM.
module sort_collector_ram #(
   parameter int SIZE  = 1024,
   parameter int WIDTH = 32,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [SIZE];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; output holds when re is low.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sort_collector.sv
// Captures the sorter's unload burst into local RAM, then replays it on a
// valid/ready stream with m_last on the final word. The RAM read register
// doubles as the prefetch entry in front of the output register, giving
// one word per cycle when the consumer never stalls.
module sort_collector
   import sort_pkg::*;
#(
   parameter int SIZE       = 1024,
   parameter int WIDTH      = 32,
   parameter bit DESCENDING = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           sort_q,
   input  logic                       sort_active_output,
   output logic [WIDTH-1:0]           m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       m_last,
   output logic [clog2(SIZE+1)-1:0]   count,
   output logic                       busy,
   output logic                       overflow,
   output logic                       overrun
);

   localparam int PW = clog2(SIZE + 1);
   localparam int AW = (clog2(SIZE) < 1) ? 1 : clog2(SIZE);
   localparam logic [PW-1:0] SIZE_P = PW'(SIZE);

   state_t           state;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    issued;     // replay words read out of RAM so far
   logic [PW-1:0]    count_r;
   // [0]: RAM read register holds a word, [1]: output register holds a word
   logic [1:0]       vld_pipe;
   logic             skid_last;
   logic             last_r;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] ram_q;

   logic             ram_we;
   logic [AW-1:0]    ram_waddr;
   logic             out_take;
   logic             out_load;
   logic             rd_en;

   // The first word lands in RAM[0] on the same cycle IDLE sees the flag.
   assign ram_we    = sort_active_output &&
                      ((state == ST_IDLE) || ((state == ST_CAPTURE) && (wr_ptr < SIZE_P)));
   assign ram_waddr = (state == ST_IDLE) ? '0 : AW'(wr_ptr);

   // Output register refills whenever it is empty or being consumed; a new
   // RAM read is issued only if the read register is free or draining.
   assign out_take = vld_pipe[1] && m_ready;
   assign out_load = vld_pipe[0] && (!vld_pipe[1] || m_ready);
   assign rd_en    = (state == ST_DRAIN) && (issued < count_r) &&
                     (!vld_pipe[0] || out_load);

   assign m_valid = vld_pipe[1];
   assign m_data  = vld_pipe[1] ? data_r : '0;
   assign m_last  = vld_pipe[1] && last_r;
   assign count   = count_r;
   assign busy    = (state != ST_IDLE);

   sort_collector_ram #(
      .SIZE  (SIZE),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (sort_q),
      .re    (rd_en),
      .raddr (AW'(rd_ptr)),
      .rdata (ram_q)
   );

   // FSM, pointers, replay pipeline and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         issued    <= '0;
         count_r   <= '0;
         vld_pipe  <= '0;
         skid_last <= 1'b0;
         last_r    <= 1'b0;
         data_r    <= '0;
         overflow  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (out_load) begin
            vld_pipe[1] <= 1'b1;
            data_r      <= ram_q;
            last_r      <= skid_last;
         end else if (out_take) begin
            vld_pipe[1] <= 1'b0;
            last_r      <= 1'b0;
         end

         if (rd_en) begin
            vld_pipe[0] <= 1'b1;
            skid_last   <= (issued == count_r - PW'(1));
            issued      <= issued + PW'(1);
            rd_ptr      <= DESCENDING ? rd_ptr - PW'(1) : rd_ptr + PW'(1);
         end else if (out_load) begin
            vld_pipe[0] <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (sort_active_output) begin
                  wr_ptr  <= PW'(1);
                  count_r <= '0;
                  state   <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (sort_active_output) begin
                  if (wr_ptr < SIZE_P) wr_ptr   <= wr_ptr + PW'(1);
                  else                 overflow <= 1'b1;
               end else begin
                  count_r <= wr_ptr;
                  issued  <= '0;
                  rd_ptr  <= DESCENDING ? wr_ptr - PW'(1) : '0;
                  state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (sort_active_output) overrun <= 1'b1;
               if (out_take && last_r) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
